// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the pins, checks 11-bit frames, decodes set-2
// make/break codes into ASCII key-press events and queues them in a small FIFO.
module ps2_key_decoder #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_pop,
  output logic       key_valid,
  output logic [7:0] key_ascii,
  output logic [7:0] key_scan,
  output logic       shift_held,
  output logic       frame_err,
  output logic       overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] LSHIFT = 8'h12, RSHIFT = 8'h59;

  function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    logic       letter;
    a      = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      default: begin
        letter = 1'b0;
        case (code)
          8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
          8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
          8'h3E: a = 8'h38;  8'h46: a = 8'h39;  8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
          8'h66: a = 8'h08;
          default: a = 8'h00;
        endcase
      end
    endcase
    if (letter && shift) a = a - 8'h20;
    return {letter || (a != 8'h00), a};
  endfunction

  logic [2:0]    clk_sync_q, dat_sync_q;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_vld_q, byte_vld_d, ferr_q, ferr_d;
  logic [7:0]    byte_q, byte_d;
  logic          ext_q, ext_d, brk_q, brk_d, lsh_q, lsh_d, rsh_q, rsh_d;
  logic [7:0]    last_q, last_d;
  logic          push_q, push_d;
  logic [15:0]   push_data_q, push_data_d;
  logic [8:0]    map_w;
  logic [15:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic          head_vld_q, head_vld_d, ovf_q, ovf_d;
  logic [15:0]   head_q, head_d;
  logic          fall, bit_in, full, wr_en, pop_eff;

  assign fall   = (clk_sync_q[2:1] == 2'b10);
  assign bit_in = dat_sync_q[2];

  // Frame receiver: bits 0..9 are shifted in, bit 10 (stop) completes the check.
  always_comb begin
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    tmo_d      = tmo_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    ferr_d     = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (bitcnt_q == 4'd10) begin
        bitcnt_d = 4'd0;
        if (!shreg_q[0] && bit_in && (^shreg_q[9:1])) begin
          byte_vld_d = 1'b1;
          byte_d     = shreg_q[8:1];
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        shreg_d[bitcnt_q] = bit_in;
        bitcnt_d          = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        bitcnt_d = 4'd0;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign map_w = map_code(byte_q, lsh_q | rsh_q);

  // Scan-code decoder: prefix flags, shift tracking and typematic suppression.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    lsh_d       = lsh_q;
    rsh_d       = rsh_q;
    last_d      = last_q;
    push_d      = 1'b0;
    push_data_d = {map_w[7:0], byte_q};
    if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q) begin
          if (brk_q) begin
            if (byte_q == last_q) last_d = 8'h00;
            if (byte_q == LSHIFT) lsh_d = 1'b0;
            if (byte_q == RSHIFT) rsh_d = 1'b0;
          end else if (byte_q == LSHIFT) begin
            lsh_d = 1'b1;
          end else if (byte_q == RSHIFT) begin
            rsh_d = 1'b1;
          end else if (byte_q != last_q) begin
            last_d = byte_q;
            push_d = map_w[8];
          end
        end
      end
    end
  end

  // Event FIFO with a registered head; the head tracks the post-pop read pointer.
  always_comb begin
    full       = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    pop_eff    = key_pop & head_vld_q;
    wr_en      = push_q & (~full | pop_eff);
    ovf_d      = push_q & full & ~pop_eff;
    wptr_d     = wptr_q + FIFO_AW'(wr_en);
    rptr_d     = rptr_q + FIFO_AW'(pop_eff);
    cnt_d      = cnt_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop_eff);
    head_vld_d = ((cnt_q - (FIFO_AW + 1)'(pop_eff)) != '0);
    head_d     = head_vld_d ? mem_q[rptr_d] : 16'h0000;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
      bitcnt_q   <= 4'd0;
      shreg_q    <= '0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
      ferr_q     <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      lsh_q      <= 1'b0;
      rsh_q      <= 1'b0;
      last_q     <= 8'h00;
      push_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      head_vld_q <= 1'b0;
      head_q     <= 16'h0000;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data};
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      tmo_q      <= tmo_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      ferr_q     <= ferr_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      last_q     <= last_d;
      push_q     <= push_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    push_data_q <= push_data_d;
    if (wr_en) mem_q[wptr_q] <= push_data_q;
  end

  assign key_valid  = head_vld_q;
  assign key_ascii  = head_q[15:8];
  assign key_scan   = head_q[7:0];
  assign shift_held = lsh_q | rsh_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
endmodule
